// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch front end.
// FSM encodings, PC step and the skid/output entry layout.
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_SLOT = 2'd2,
    ST_DISCARD   = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_INCR = 32'd4;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] pc
  );
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction-memory read bus: one outstanding req/ack transaction.
// req and addr hold stable until the acking edge.
interface instr_fetch_ctrl_if #(
  parameter int ADDR_W = 10
);

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/instr_fetch_ctrl_skid_buf.sv
// One-entry skid store for a fetched word that found the output busy.
// clear beats load, load beats pop.
module instr_fetch_ctrl_skid_buf
  import instr_fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full
);

  // Capture on load, release on pop or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      dout <= din;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch PC, imem request FSM and IF/ID output slot with redirect flush.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect parks fetch, flags misalign_err.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  instr_fetch_ctrl_if.master imem,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic        instr_valid
);

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_nxt;
  logic [31:0] req_pc;
  logic [31:0] req_pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] pc_nxt;
  logic        valid_nxt;

  logic         skid_load;
  logic         skid_pop;
  logic         skid_clear;
  logic         skid_full;
  fetch_entry_t skid_in;
  fetch_entry_t skid_q;

  logic        slot_free;
  logic [31:0] redir_pc;
  logic        bad_redir;
  logic        parked;

  assign slot_free = !instr_valid || !stall;

  assign imem.req  = (state == ST_REQ) || (state == ST_DISCARD);
  assign imem.addr = req_pc[ADDR_W+1:2];

  assign skid_in = '{data: imem.rdata, pc: req_pc};

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_pc  = redirect_pc;
  assign bad_redir = redirect_pc[1:0] != 2'b00;
  assign parked    = misalign_err;

  // Sticky alignment fault; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else if (redirect && bad_redir) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign redir_pc  = word_align(redirect_pc);
  assign bad_redir = 1'b0;
  assign parked    = 1'b0;
`endif

  instr_fetch_ctrl_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .pop   (skid_pop),
    .clear (skid_clear),
    .din   (skid_in),
    .dout  (skid_q),
    .full  (skid_full)
  );

  // Next state, PC update and output-slot loading; redirect wins.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    instr_nxt    = instr_out;
    pc_nxt       = pc_out;
    valid_nxt    = instr_valid && stall;
    skid_load    = 1'b0;
    skid_pop     = 1'b0;
    skid_clear   = 1'b0;
    if (parked) begin
      state_nxt = ST_IDLE;
    end else if (redirect) begin
      valid_nxt    = 1'b0;
      skid_clear   = 1'b1;
      fetch_pc_nxt = redir_pc;
      if (bad_redir) begin
        state_nxt = ST_IDLE;
      end else if (imem.req && !imem.ack) begin
        state_nxt = ST_DISCARD;
      end else begin
        state_nxt  = ST_REQ;
        req_pc_nxt = redir_pc;
      end
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt  = ST_REQ;
          req_pc_nxt = fetch_pc;
        end
        ST_REQ: begin
          if (imem.ack) begin
            if (slot_free) begin
              instr_nxt    = imem.rdata;
              pc_nxt       = req_pc;
              valid_nxt    = 1'b1;
              fetch_pc_nxt = fetch_pc + PC_INCR;
              req_pc_nxt   = fetch_pc + PC_INCR;
            end else begin
              skid_load = 1'b1;
              state_nxt = ST_WAIT_SLOT;
            end
          end
        end
        ST_WAIT_SLOT: begin
          if (slot_free && skid_full) begin
            instr_nxt    = skid_q.data;
            pc_nxt       = skid_q.pc;
            valid_nxt    = 1'b1;
            skid_pop     = 1'b1;
            fetch_pc_nxt = fetch_pc + PC_INCR;
            req_pc_nxt   = fetch_pc + PC_INCR;
            state_nxt    = ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (imem.ack) begin
            state_nxt  = ST_REQ;
            req_pc_nxt = fetch_pc;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // PC registers and the IF/ID output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      req_pc      <= req_pc_nxt;
      instr_out   <= instr_nxt;
      pc_out      <= pc_nxt;
      instr_valid <= valid_nxt;
    end
  end

endmodule
